// File: rtl/soc_mem_pkg.sv
// Shared types and address helpers for the banked SoC memory controller.
// Bank/word split works on a 32-bit word address so one helper fits any width.
package soc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE,
    DONE
  } mem_state_t;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  function automatic int bank_bits(input int nb);
    return (nb > 1) ? $clog2(nb) : 0;
  endfunction

  function automatic int bank_idx_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  function automatic int word_bits(input int aw, input int nb);
    return aw - 2 - bank_bits(nb);
  endfunction

  function automatic logic [3:0] bank_of(
    input logic [31:0] wa,
    input logic        il,
    input int          bw,
    input int          iw
  );
    logic [31:0] mask;
    mask = (32'd1 << bw) - 32'd1;
    if (il) return 4'(wa & mask);
    return 4'((wa >> iw) & mask);
  endfunction

  function automatic logic [31:0] word_of(
    input logic [31:0] wa,
    input logic        il,
    input int          bw,
    input int          iw
  );
    if (il) return wa >> bw;
    return wa & ((32'd1 << iw) - 32'd1);
  endfunction

endpackage

// File: rtl/soc_mem_bus.sv
// SoC memory bus: single outstanding request, valid held while req holds.
// read_data is only meaningful (and only driven) while valid is high.
interface SoC_MemBus;
  logic        req;
  logic [31:0] addr;
  logic        write_en;
  logic [3:0]  byte_en;
  logic [31:0] read_data;
  logic        valid;

  modport Master (
    output req, addr, write_en, byte_en,
    input  read_data, valid
  );

  modport Slave (
    input  req, addr, write_en, byte_en,
    output read_data, valid
  );
endinterface

// File: rtl/soc_banked_memory_controller_decoder.sv
// Word address -> {bank index, in-bank word}.
// Interleaved maps low word bits to the bank; contiguous uses the top bits.
module soc_bank_decoder
  import soc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_BANKS  = 4,
  parameter int INTERLEAVE = 1
) (
  input  logic [ADDR_WIDTH-3:0]                       word_addr,
  output logic [bank_idx_w(NUM_BANKS)-1:0]            bank,
  output logic [word_bits(ADDR_WIDTH, NUM_BANKS)-1:0] word
);

  localparam int BW  = bank_bits(NUM_BANKS);
  localparam int BIW = bank_idx_w(NUM_BANKS);
  localparam int IW  = word_bits(ADDR_WIDTH, NUM_BANKS);

  logic [31:0] wa;

  always_comb begin
    wa   = 32'(word_addr);
    bank = BIW'(bank_of(wa, INTERLEAVE != 0, BW, IW));
    word = IW'(word_of(wa, INTERLEAVE != 0, BW, IW));
  end

endmodule

// File: rtl/soc_banked_memory_controller.sv
// SoC_MemBus slave over NUM_BANKS BRAM banks: latched request tuple,
// fast single-strobe writes, counted read latency, abort on tuple change.
module soc_banked_memory_controller
  import soc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_BANKS  = 4,
  parameter int LATENCY    = 1,
  parameter int INTERLEAVE = 1
) (
  input  logic                                        clk,
  input  logic                                        res_n,
  SoC_MemBus.Slave                                    bus,
  input  logic [NUM_BANKS*DATA_W-1:0]                 mem_data_out,
  output logic [word_bits(ADDR_WIDTH, NUM_BANKS)-1:0] word_addr_out,
  output logic [NUM_BANKS-1:0]                        mem_en,
  output logic [NUM_BANKS*BE_W-1:0]                   mem_we,
  output logic                                        busy
);

  localparam int IW  = word_bits(ADDR_WIDTH, NUM_BANKS);
  localparam int BIW = bank_idx_w(NUM_BANKS);
  localparam int CW  = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY + 1);

  mem_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_W-1:0]       be_q, be_d;

  logic           changed;
  logic           take;
  logic           active;
  logic           valid;
  logic [BIW-1:0] bank;
  logic [IW-1:0]  word;
  logic           unused_addr;

  assign unused_addr = ^bus.addr[31:ADDR_WIDTH];

  soc_bank_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BANKS  (NUM_BANKS),
    .INTERLEAVE (INTERLEAVE)
  ) u_dec (
    .word_addr (addr_q[ADDR_WIDTH-1:2]),
    .bank      (bank),
    .word      (word)
  );

  assign changed = (bus.addr[ADDR_WIDTH-1:0] != addr_q)
                 || (bus.write_en != we_q)
                 || (bus.byte_en != be_q);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: take = bus.req;
      WAIT: begin
        if (!bus.req) state_d = IDLE;
        else if (changed) take = 1'b1;
        else if (cnt_q == CW'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q - CW'(1);
      end
      WRITE: begin
        if (!bus.req) state_d = IDLE;
        else if (changed) take = 1'b1;
        else state_d = DONE;
      end
      DONE: begin
        if (!bus.req) state_d = IDLE;
        else if (changed) take = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // a changed tuple is re-latched on the same edge: zero turnaround
    if (take) begin
      addr_d  = bus.addr[ADDR_WIDTH-1:0];
      we_d    = bus.write_en;
      be_d    = bus.byte_en;
      state_d = bus.write_en ? WRITE : WAIT;
      cnt_d   = CNT_INIT;
    end
  end

  assign active = (state_q != IDLE);
  assign busy   = (state_q == WAIT) || (state_q == WRITE);
  assign valid  = (state_q == DONE) && bus.req && !changed;

  always_comb begin
    mem_en        = '0;
    mem_we        = '0;
    word_addr_out = '0;
    if (active) begin
      mem_en[bank]  = 1'b1;
      word_addr_out = word;
    end
    if (state_q == WRITE) mem_we[bank*BE_W +: BE_W] = be_q;
  end

  assign bus.valid     = valid;
  assign bus.read_data = valid ? mem_data_out[bank*DATA_W +: DATA_W] : 'z;

endmodule
